// File: rtl/exibidor_decimal_pkg.sv
// Shared definitions for the decimal display path: segment constants,
// FSM encoding and the digit-to-segment lookup (active-low, a..g from MSB).
package exibidor_decimal_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_TRACO = 7'b1111110;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONVERTE = 2'd1,
        ATUALIZA = 2'd2
    } estado_t;

    function automatic logic [6:0] digito_para_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/exibidor_decimal_bcd7seg.sv
// One BCD digit to active-low seven-segment pattern, with a blank enable
// so leading-zero suppression is decided by the caller.
module bcd7seg
    import exibidor_decimal_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       apagar,
    output logic [0:6] seg
);

    always_comb begin
        seg = apagar ? SEG_BLANK : digito_para_seg(bcd);
    end

endmodule

// File: rtl/exibidor_decimal.sv
// Binary-to-BCD display driver: serial shift-add-3 conversion, leading-zero
// blanking, overflow dash and a field-index digit, all updated atomically.
module exibidor_decimal
    import exibidor_decimal_pkg::*;
#(
    parameter int LARGURA = 14,
    parameter int DIGITOS = 4
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    input  logic [LARGURA-1:0] valor,
    input  logic               valor_valido,
    output logic               pronto,
    input  logic [2:0]         indice,
    output logic [0:6]         HEX3,
    output logic [0:6]         HEX2,
    output logic [0:6]         HEX1,
    output logic [0:6]         HEX0,
    output logic [0:6]         HEX5
);

    localparam int BW     = 4 * DIGITOS;
    localparam int CW     = $clog2(LARGURA + 1);
    localparam int LIMITE = 10 ** DIGITOS - 1;

    estado_t            estado_q, estado_d;
    logic [LARGURA-1:0] desl_q, desl_d;
    logic [BW-1:0]      bcd_q, bcd_d;
    logic [CW-1:0]      cont_q, cont_d;
    logic [2:0]         indice_q, indice_d;
    logic               excede_q, excede_d;
    logic               pronto_q, pronto_d;
    logic [0:6]         hex_q [5];
    logic [0:6]         hex_d [5];

    logic [BW-1:0]      bcd_aj;
    logic [DIGITOS-1:0] apagar;
    logic               zeros_acima;
    logic [0:6]         seg_dig [DIGITOS];
    logic [0:6]         seg_idx;

    // A digit is blank when it and everything above it is zero; units never blank.
    always_comb begin
        apagar      = '0;
        zeros_acima = 1'b1;
        for (int i = DIGITOS - 1; i >= 0; i--) begin
            zeros_acima = zeros_acima && (bcd_q[4*i +: 4] == 4'd0);
            apagar[i]   = zeros_acima && (i != 0);
        end
    end

    for (genvar g = 0; g < DIGITOS; g++) begin : g_dig
        bcd7seg u_dig (
            .bcd    (bcd_q[4*g +: 4]),
            .apagar (apagar[g]),
            .seg    (seg_dig[g])
        );
    end

    bcd7seg u_idx (
        .bcd    ({1'b0, indice_q}),
        .apagar (1'b0),
        .seg    (seg_idx)
    );

    always_comb begin
        bcd_aj = bcd_q;
        for (int i = 0; i < DIGITOS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_aj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        estado_d = estado_q;
        desl_d   = desl_q;
        bcd_d    = bcd_q;
        cont_d   = cont_q;
        indice_d = indice_q;
        excede_d = excede_q;
        pronto_d = pronto_q;
        hex_d    = hex_q;
        case (estado_q)
            OCIOSO: begin
                if (valor_valido) begin
                    desl_d   = valor;
                    indice_d = indice;
                    excede_d = (int'(valor) > LIMITE);
                    bcd_d    = '0;
                    cont_d   = CW'(LARGURA);
                    estado_d = CONVERTE;
                    pronto_d = 1'b0;
                end
            end
            CONVERTE: begin
                {bcd_d, desl_d} = {bcd_aj[BW-2:0], desl_q, 1'b0};
                cont_d = cont_q - CW'(1);
                if (cont_q == CW'(1)) begin
                    estado_d = ATUALIZA;
                end
            end
            ATUALIZA: begin
                for (int i = 0; i < 4; i++) begin
                    hex_d[i] = excede_q ? SEG_TRACO : seg_dig[i];
                end
                hex_d[4] = seg_idx;
                estado_d = OCIOSO;
                pronto_d = 1'b1;
            end
            default: begin
                estado_d = OCIOSO;
                pronto_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            estado_q <= OCIOSO;
            desl_q   <= '0;
            bcd_q    <= '0;
            cont_q   <= '0;
            indice_q <= '0;
            excede_q <= 1'b0;
            pronto_q <= 1'b1;
            for (int i = 0; i < 5; i++) begin
                hex_q[i] <= SEG_BLANK;
            end
        end else begin
            estado_q <= estado_d;
            desl_q   <= desl_d;
            bcd_q    <= bcd_d;
            cont_q   <= cont_d;
            indice_q <= indice_d;
            excede_q <= excede_d;
            pronto_q <= pronto_d;
            hex_q    <= hex_d;
        end
    end

    assign pronto = pronto_q;
    assign HEX0   = hex_q[0];
    assign HEX1   = hex_q[1];
    assign HEX2   = hex_q[2];
    assign HEX3   = hex_q[3];
    assign HEX5   = hex_q[4];

endmodule
